// File: rtl/fan_mon_pkg.sv
// Shared definitions for the fan monitor and the fan status LED logic:
// FSM encoding, default clocking constants and the fan-fail polarity.
package fan_mon_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int SLOWCLK_HZ = 32768;
  localparam int STROBE_DIV = 512;

  localparam logic FAN_FAIL_ACTIVE = 1'b1;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fan_tach_channel.sv
// One tach input: synchronizer, rising-edge detector, saturating pulse
// counter, per-window count latch and consecutive-low-window fail tracking.
module fan_tach_channel
  import fan_mon_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MIN_PULSES   = 8,
  parameter int FAIL_WINDOWS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tach_in,
  input  logic             present,
  input  logic             window_end,
  input  logic             run,
  output logic [CNT_W-1:0] tach_count,
  output logic             fail,
  output logic             fail_next
);

  localparam int               LOW_W   = cnt_width(FAIL_WINDOWS + 1);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(FAIL_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PULSES);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             sync_dly_q, sync_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tach_count_q, tach_count_d;
  logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
  logic             fail_q, fail_d;
  logic             rise;

  always_comb begin
    meta_d       = tach_in;
    sync_d       = meta_q;
    sync_dly_d   = sync_q;
    rise         = sync_q & ~sync_dly_q;
    cnt_d        = cnt_q;
    tach_count_d = tach_count_q;
    low_cnt_d    = low_cnt_q;
    fail_d       = fail_q;
    if (window_end) begin
      // An edge seen on the window-end cycle opens the new window's count.
      cnt_d        = CNT_W'(rise);
      tach_count_d = cnt_q;
      if (run) begin
        if (!present) begin
          low_cnt_d = '0;
        end else if (cnt_q < CNT_MIN) begin
          low_cnt_d = (low_cnt_q == LOW_MAX) ? LOW_MAX : low_cnt_q + LOW_W'(1);
        end else begin
          low_cnt_d = '0;
        end
        fail_d = present && (low_cnt_d == LOW_MAX);
      end
    end else if (rise && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      sync_dly_q   <= 1'b0;
      cnt_q        <= '0;
      tach_count_q <= '0;
      low_cnt_q    <= '0;
      fail_q       <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      sync_dly_q   <= sync_dly_d;
      cnt_q        <= cnt_d;
      tach_count_q <= tach_count_d;
      low_cnt_q    <= low_cnt_d;
      fail_q       <= fail_d;
    end
  end

  assign tach_count = tach_count_q;
  assign fail       = fail_q;
  assign fail_next  = fail_d;

endmodule

// File: rtl/fan_tach_monitor.sv
// Fan tach monitor top: Strobe16ms prescaler, measurement window counter,
// INIT/RUN spin-up FSM and the registered Beep fan-fail output.
module fan_tach_monitor
  import fan_mon_pkg::*;
#(
  parameter int NUM_FANS       = 4,
  parameter int STROBE_DIV     = fan_mon_pkg::STROBE_DIV,
  parameter int WINDOW_STROBES = 64,
  parameter int MIN_PULSES     = 8,
  parameter int FAIL_WINDOWS   = 2,
  parameter int CNT_W          = 8
) (
  input  logic                      SlowClock,
  input  logic                      Reset,
  input  logic [NUM_FANS-1:0]       FanTach,
  input  logic [NUM_FANS-1:0]       FanPresentMask,
  output logic                      Strobe16ms,
  output logic                      WindowDone,
  output logic [NUM_FANS*CNT_W-1:0] TachCount,
  output logic [NUM_FANS-1:0]       FanFailVec,
  output logic                      Beep
);

  localparam int                 PRESC_W    = cnt_width(STROBE_DIV);
  localparam int                 WIN_W      = cnt_width(WINDOW_STROBES);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STROBE_DIV - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_STROBES - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                strobe_q, strobe_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [0:0]          state_q, state_d;
  logic                beep_q, beep_d;
  logic                window_end;
  logic                run;
  logic [NUM_FANS-1:0] fail_next;

  always_comb begin
    presc_d    = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    strobe_d   = (presc_q == PRESC_LAST);
    window_end = strobe_q && (win_q == WIN_LAST);
    win_d      = win_q;
    if (strobe_q) begin
      win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
    end
    // The first window after reset is spin-up; fail tracking starts in RUN.
    state_d = state_q;
    if ((state_q == ST_INIT) && window_end) begin
      state_d = ST_RUN;
    end
    run = (state_q == ST_RUN);
  end

  always_comb begin
    beep_d = beep_q;
    if (window_end) begin
      beep_d = (|(fail_next & FanPresentMask)) ? FAN_FAIL_ACTIVE : ~FAN_FAIL_ACTIVE;
    end
  end

  always_ff @(posedge SlowClock or posedge Reset) begin
    if (Reset) begin
      presc_q  <= '0;
      strobe_q <= 1'b0;
      win_q    <= '0;
      state_q  <= ST_INIT;
      beep_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      strobe_q <= strobe_d;
      win_q    <= win_d;
      state_q  <= state_d;
      beep_q   <= beep_d;
    end
  end

  for (genvar i = 0; i < NUM_FANS; i++) begin : g_ch
    fan_tach_channel #(
      .CNT_W        (CNT_W),
      .MIN_PULSES   (MIN_PULSES),
      .FAIL_WINDOWS (FAIL_WINDOWS)
    ) u_ch (
      .clk        (SlowClock),
      .rst        (Reset),
      .tach_in    (FanTach[i]),
      .present    (FanPresentMask[i]),
      .window_end (window_end),
      .run        (run),
      .tach_count (TachCount[i*CNT_W +: CNT_W]),
      .fail       (FanFailVec[i]),
      .fail_next  (fail_next[i])
    );
  end

  assign Strobe16ms = strobe_q;
  assign WindowDone = window_end;
  assign Beep       = beep_q;

endmodule
